// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - request size codes and FSM state encoding
//   - data-memory geometry (word count, byte-address bits used as word index)
//   - latched request payload struct
//   - request legality check (alignment, reserved size, address range)
package lsu_pkg;

    localparam int unsigned DM_WORDS = 3072;
    localparam int unsigned ADDR_LO  = 2;
    localparam int unsigned ADDR_HI  = 13;
    localparam int unsigned IDX_W    = ADDR_HI - ADDR_LO + 1;
    localparam int unsigned XLEN     = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    typedef struct packed {
        logic            we;
        size_e           size;
        logic            sign;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] pc;
    } req_t;

    // 1 when the request must be rejected without touching memory.
    function automatic logic req_error(input size_e size, input logic [XLEN-1:0] addr);
        logic err;
        err = 1'b0;
        case (size)
            SZ_HALF: err = addr[0];
            SZ_WORD: err = |addr[1:0];
            SZ_RSVD: err = 1'b1;
            default: err = 1'b0;
        endcase
        if (|addr[XLEN-1:ADDR_HI+1]) begin
            err = 1'b1;
        end
        if (32'(addr[ADDR_HI:ADDR_LO]) >= 32'(DM_WORDS)) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte/half lane logic.
//   word       : memory word read during the RMW / load
//   lane       : byte offset addr[1:0]
//   size/sign  : access size and load sign-extension select
//   wdata      : right-aligned store data
//   load_data  : selected lane, zero- or sign-extended to 32 bits
//   merge_data : word with the store lane replaced (wdata itself for word stores)
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  size_e           size,
    input  logic            sign,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [4:0]      byte_sh;
    logic [4:0]      half_sh;
    logic [XLEN-1:0] byte_word;
    logic [XLEN-1:0] half_word;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] byte_mask;
    logic [XLEN-1:0] half_mask;

    // Little-endian lane select: byte lane = addr[1:0], half lane = addr[1].
    always_comb begin
        byte_sh   = {lane, 3'b000};
        half_sh   = {lane[1], 4'b0000};
        byte_word = word >> byte_sh;
        half_word = word >> half_sh;
        byte_v    = byte_word[7:0];
        half_v    = half_word[15:0];
        byte_mask = 32'h0000_00FF << byte_sh;
        half_mask = 32'h0000_FFFF << half_sh;
    end

    // Load extraction with optional sign extension.
    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{sign & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{sign & half_v[15]}}, half_v};
            default: load_data = word;
        endcase
    end

    // Store merge into the read word.
    always_comb begin
        merge_data = wdata;
        case (size)
            SZ_BYTE: merge_data = (word & ~byte_mask) | ((32'(wdata[7:0]) << byte_sh) & byte_mask);
            SZ_HALF: merge_data = (word & ~half_mask) | ((32'(wdata[15:0]) << half_sh) & half_mask);
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of a word-only data memory.
//   req_*      : valid/ready request channel from the MEM stage
//   resp_*     : one-cycle response pulse (err qualifies, rdata for loads)
//   mem_*      : word-indexed memory port, combinational mem_rdata
// Sub-word stores do a read-modify-write (READ then WRITE); errors go
// straight to RESP and never write memory.
module lsu_rmw
    import lsu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_sign,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    input  logic [XLEN-1:0]  req_pc,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [XLEN-1:0]  mem_pc,
    output logic [XLEN-1:0]  mem_full_addr
);

    state_e          state;
    state_e          state_next;
    req_t            lat_q;
    logic            err_q;
    logic [XLEN-1:0] rd_word;
    logic            req_err_c;
    logic            accept_c;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    assign req_err_c = req_error(size_e'(req_size), req_addr);
    assign accept_c  = (state == ST_IDLE) && req_valid;

    lsu_lane u_lane (
        .word       (rd_word),
        .lane       (lat_q.addr[1:0]),
        .size       (lat_q.size),
        .sign       (lat_q.sign),
        .wdata      (lat_q.wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch and read-word capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_q   <= '0;
            err_q   <= 1'b0;
            rd_word <= '0;
        end else begin
            if (accept_c) begin
                lat_q.we    <= req_we;
                lat_q.size  <= size_e'(req_size);
                lat_q.sign  <= req_sign;
                lat_q.addr  <= req_addr;
                lat_q.wdata <= req_wdata;
                lat_q.pc    <= req_pc;
                err_q       <= req_err_c;
            end
            if (state == ST_READ) begin
                rd_word <= mem_rdata;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err_c) begin
                        state_next = ST_RESP;
                    end else if (req_we && (size_e'(req_size) == SZ_WORD)) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ:  state_next = lat_q.we ? ST_WRITE : ST_RESP;
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and latches. mem_we is masked by reset so a
    // reset landing on the WRITE cycle cannot commit the abandoned store.
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_rdata    = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        mem_addr      = lat_q.addr[ADDR_HI:ADDR_LO];
        mem_pc        = lat_q.pc;
        mem_full_addr = {lat_q.addr[XLEN-1:ADDR_LO], 2'b00};
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_WRITE: begin
                mem_we    = ~reset;
                mem_wdata = merge_data;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!lat_q.we && !err_q) begin
                    resp_rdata = load_data;
                end
            end
            default: ;
        endcase
    end

endmodule
